// File: rtl/uart_cmd_seq.sv
// Command sequencer: parses l/L MMSS<CR> and 'a' from the UART receive stream,
// issues single-cycle load strobes with the BCD value and answers with one tx byte.
module uart_cmd_seq #(
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic        clk12m,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_rdy,
    output logic        ld_time,
    output logic        ld_alarm,
    output logic [15:0] ld_value,
    output logic        alarm_en,
    output logic [7:0]  tx_data,
    output logic        tx_data_rdy,
    output logic        busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_L_LO = 8'h6C;
    localparam logic [7:0] CH_L_UP = 8'h4C;
    localparam logic [7:0] CH_A_LO = 8'h61;
    localparam logic [7:0] CH_A_UP = 8'h41;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_OK   = 8'h21;
    localparam logic [7:0] CH_ERR  = 8'h3F;

    typedef enum logic [2:0] {S_IDLE, S_D0, S_D1, S_D2, S_D3, S_WCR} state_t;

    state_t           r_state;
    logic [15:0]      r_shadow;
    logic             r_target;     // 0: time counter, 1: alarm register
    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm_en;
    logic             r_ld_time;
    logic             r_ld_alarm;
    logic [15:0]      r_ld_value;
    logic [7:0]       r_tx_data;
    logic             r_tx_rdy;

    state_t           w_state_next;
    logic [15:0]      w_shadow_next;
    logic             w_target_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_alarm_next;
    logic             w_ld_time;
    logic             w_ld_alarm;
    logic             w_tx_fire;
    logic [7:0]       w_tx_byte;
    logic             w_abort;
    logic [7:0]       w_dig;
    logic             w_dig05;
    logic             w_dig09;

    assign w_dig   = rx_data - 8'h30;
    assign w_dig05 = (rx_data >= 8'h30) && (rx_data <= 8'h35);
    assign w_dig09 = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    always_comb begin
        w_state_next  = r_state;
        w_shadow_next = r_shadow;
        w_target_next = r_target;
        w_cnt_next    = r_cnt;
        w_alarm_next  = r_alarm_en;
        w_ld_time     = 1'b0;
        w_ld_alarm    = 1'b0;
        w_tx_fire     = 1'b0;
        w_tx_byte     = r_tx_data;
        w_abort       = 1'b0;

        // A byte always takes precedence over the idle timeout.
        if (rx_data_rdy) begin
            w_cnt_next = '0;
            case (r_state)
                S_IDLE: begin
                    if (rx_data == CH_L_LO || rx_data == CH_L_UP) begin
                        w_state_next  = S_D0;
                        w_target_next = (rx_data == CH_L_UP);
                        w_shadow_next = 16'h0000;
                    end else if (rx_data == CH_A_LO) begin
                        w_alarm_next = ~r_alarm_en;
                        w_tx_fire    = 1'b1;
                        w_tx_byte    = r_alarm_en ? CH_A_LO : CH_A_UP;
                    end
                end
                S_D0: if (w_dig05) begin
                    w_shadow_next[15:12] = w_dig[3:0];
                    w_state_next = S_D1;
                end else w_abort = 1'b1;
                S_D1: if (w_dig09) begin
                    w_shadow_next[11:8] = w_dig[3:0];
                    w_state_next = S_D2;
                end else w_abort = 1'b1;
                S_D2: if (w_dig05) begin
                    w_shadow_next[7:4] = w_dig[3:0];
                    w_state_next = S_D3;
                end else w_abort = 1'b1;
                S_D3: if (w_dig09) begin
                    w_shadow_next[3:0] = w_dig[3:0];
                    w_state_next = S_WCR;
                end else w_abort = 1'b1;
                S_WCR: if (rx_data == CH_CR) begin
                    w_ld_time    = ~r_target;
                    w_ld_alarm   = r_target;
                    w_tx_fire    = 1'b1;
                    w_tx_byte    = CH_OK;
                    w_state_next = S_IDLE;
                end else w_abort = 1'b1;
                default: w_state_next = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_cnt == CNT_LAST) w_abort = 1'b1;
            else                   w_cnt_next = r_cnt + CNT_W'(1);
        end

        if (w_abort) begin
            w_state_next  = S_IDLE;
            w_shadow_next = 16'h0000;
            w_cnt_next    = '0;
            w_tx_fire     = 1'b1;
            w_tx_byte     = CH_ERR;
        end
    end

    always_ff @(posedge clk12m) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shadow   <= 16'h0000;
            r_target   <= 1'b0;
            r_cnt      <= '0;
            r_alarm_en <= 1'b0;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_ld_value <= 16'h0000;
            r_tx_data  <= 8'h00;
            r_tx_rdy   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shadow   <= w_shadow_next;
            r_target   <= w_target_next;
            r_cnt      <= w_cnt_next;
            r_alarm_en <= w_alarm_next;
            r_ld_time  <= w_ld_time;
            r_ld_alarm <= w_ld_alarm;
            r_tx_rdy   <= w_tx_fire;
            if (w_ld_time || w_ld_alarm) r_ld_value <= r_shadow;
            if (w_tx_fire)               r_tx_data  <= w_tx_byte;
        end
    end

    assign ld_time     = r_ld_time;
    assign ld_alarm    = r_ld_alarm;
    assign ld_value    = r_ld_value;
    assign alarm_en    = r_alarm_en;
    assign tx_data     = r_tx_data;
    assign tx_data_rdy = r_tx_rdy;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Bench for uart_cmd_seq: directed scenarios plus random command streams, every
// cycle compared against a byte-queue model of the command language.
module tb_uart_cmd_seq;

    localparam int TO = 16;
    localparam logic [7:0] CR = 8'h0D;

    logic        clk12m = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_rdy = 1'b0;
    logic        ld_time, ld_alarm, alarm_en, tx_data_rdy, busy;
    logic [15:0] ld_value;
    logic [7:0]  tx_data;

    uart_cmd_seq #(.TIMEOUT_CYC(TO)) dut (
        .clk12m(clk12m), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .ld_value(ld_value),
        .alarm_en(alarm_en), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .busy(busy)
    );

    always #5 clk12m = ~clk12m;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bytes of the command in progress (empty queue = idle).
    logic [7:0]  m_cmd[$];
    logic        m_alarm = 1'b0, m_ld_t = 1'b0, m_ld_a = 1'b0, m_tx_rdy = 1'b0;
    logic [15:0] m_value = 16'h0000;
    logic [7:0]  m_tx = 8'h00;
    int          m_cyc = 0, m_last = 0;

    wire [28:0] dut_vec = {ld_time, ld_alarm, ld_value, alarm_en, tx_data, tx_data_rdy, busy};

    function automatic logic [28:0] exp_vec();
        return {m_ld_t, m_ld_a, m_value, m_alarm, m_tx, m_tx_rdy, m_cmd.size() != 0};
    endfunction

    function automatic int dval(input logic [7:0] c);
        return int'(c) - 48;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [7:0] b);
        int pos;
        bit ok;
        m_cyc++;
        m_ld_t = 0; m_ld_a = 0; m_tx_rdy = 0;
        if (r) begin
            m_cmd.delete(); m_alarm = 0; m_value = 0; m_tx = 0;
        end else if (v) begin
            m_last = m_cyc;
            if (m_cmd.size() == 0) begin
                if (b == "l" || b == "L") m_cmd.push_back(b);
                else if (b == "a") begin
                    m_alarm = !m_alarm; m_tx = m_alarm ? "A" : "a"; m_tx_rdy = 1;
                end
            end else begin
                pos = m_cmd.size();
                if (pos == 5)                ok = (b == CR);
                else if (pos == 1 || pos == 3) ok = (b >= "0" && b <= "5");
                else                         ok = (b >= "0" && b <= "9");
                if (!ok) begin
                    m_tx = "?"; m_tx_rdy = 1; m_cmd.delete();
                end else if (pos < 5) begin
                    m_cmd.push_back(b);
                end else begin
                    m_value = 16'(dval(m_cmd[1]) * 4096 + dval(m_cmd[2]) * 256 +
                                  dval(m_cmd[3]) * 16 + dval(m_cmd[4]));
                    if (m_cmd[0] == "l") m_ld_t = 1; else m_ld_a = 1;
                    m_tx = "!"; m_tx_rdy = 1; m_cmd.delete();
                end
            end
        end else if (m_cmd.size() != 0 && m_cyc - m_last == TO) begin
            m_tx = "?"; m_tx_rdy = 1; m_cmd.delete();
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, settle 1 time unit after.
    task automatic drive(input logic r, input logic v, input logic [7:0] b);
        rst = r;
        rx_data_rdy = v;
        rx_data = v ? b : 8'($urandom);
        @(posedge clk12m);
        model_step(r, v, b);
        #1;
        rst = 1'b0;
        rx_data_rdy = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0);
        drive(1, 0, 0);
        n_tests++;
        if (dut_vec !== 29'd0) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec, 29'd0);
        end
        drive(0, 0, 0);
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_load_time();
        logic [7:0] seq[$] = '{"l", "5", "9", "5", "5", CR};
        foreach (seq[i]) begin
            drive(0, 1, seq[i]);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL load_time byte %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if ({ld_time, ld_alarm, ld_value, tx_data_rdy, tx_data, busy} !== {2'b10, 16'h5955, 1'b1, 8'h21, 1'b0}) begin
            n_fail++; $display("FAIL load_time_result: got t=%b a=%b v=%h tx=%b/%h busy=%b required t=1 a=0 v=5955 tx=1/21 busy=0",
                               ld_time, ld_alarm, ld_value, tx_data_rdy, tx_data, busy);
        end
        drive(0, 0, 0);
        n_tests++;
        if ({ld_time, tx_data_rdy, ld_value} !== {2'b00, 16'h5955}) begin
            n_fail++; $display("FAIL load_time_one_cycle: got t=%b tx=%b v=%h required 0 0 5955", ld_time, tx_data_rdy, ld_value);
        end
    endtask

    task automatic test_load_alarm();
        logic [7:0] seq[$] = '{"L", "0", "3", "2", "4", CR};
        bit saw_t = 0;
        int n_a = 0;
        foreach (seq[i]) begin
            drive(0, 1, seq[i]);
            saw_t |= ld_time; n_a += int'(ld_alarm);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL load_alarm byte %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            for (int g = 0; g < 5; g++) begin
                drive(0, 0, 0);
                saw_t |= ld_time; n_a += int'(ld_alarm);
                n_tests++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL load_alarm gap: got %h expected %h", dut_vec, exp_vec());
                end
            end
        end
        n_tests++;
        if ({saw_t, n_a, ld_value, alarm_en} !== {1'b0, 32'd1, 16'h0324, 1'b0}) begin
            n_fail++; $display("FAIL load_alarm_result: got ld_time_seen=%b alarm_pulses=%0d v=%h en=%b required 0 1 0324 0",
                               saw_t, n_a, ld_value, alarm_en);
        end
    endtask

    task automatic test_errors();
        logic [7:0] seq[$] = '{"l", "6", "l", "1", "2", CR, "l", "0", "0", "0", "0", "x"};
        int n_err = 0;
        foreach (seq[i]) begin
            drive(0, 1, seq[i]);
            if (tx_data_rdy && tx_data == "?") n_err++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL errors byte %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if ({n_err, ld_value, busy} !== {32'd3, 16'h0324, 1'b0}) begin
            n_fail++; $display("FAIL errors_result: got errs=%0d v=%h busy=%b required 3 0324 0", n_err, ld_value, busy);
        end
    endtask

    task automatic test_timeout();
        int lat = -1;
        drive(0, 1, "l");
        drive(0, 1, "1");
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            drive(0, 0, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL timeout cycle %0d: got %h expected %h", k, dut_vec, exp_vec());
            end
            if (tx_data_rdy) lat = k;
        end
        n_tests++;
        if (lat != TO || tx_data !== "?" || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles tx=%h busy=%b required %0d 3f 0", lat, tx_data, busy, TO);
        end
        drive(0, 1, "1");
        n_tests++;
        if (tx_data_rdy !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle_digit: got tx=%b busy=%b required 0 0", tx_data_rdy, busy);
        end
        // A byte landing on the terminal-count cycle keeps the command alive.
        drive(0, 1, "l");
        for (int k = 0; k < TO - 1; k++) drive(0, 0, 0);
        drive(0, 1, "1");
        n_tests++;
        if (tx_data_rdy !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_race: got tx=%b busy=%b required 0 1", tx_data_rdy, busy);
        end
        drive(0, 1, "2"); drive(0, 1, "3"); drive(0, 1, "4"); drive(0, 1, CR);
        n_tests++;
        if ({ld_time, ld_value, tx_data} !== {1'b1, 16'h1234, 8'h21}) begin
            n_fail++; $display("FAIL timeout_race_load: got t=%b v=%h tx=%h required 1 1234 21", ld_time, ld_value, tx_data);
        end
    endtask

    task automatic test_alarm();
        drive(0, 1, "a");
        n_tests++;
        if ({alarm_en, tx_data_rdy, tx_data} !== {2'b11, 8'h41}) begin
            n_fail++; $display("FAIL alarm_on: got en=%b tx=%b/%h required 1 1/41", alarm_en, tx_data_rdy, tx_data);
        end
        drive(0, 1, "a");
        n_tests++;
        if ({alarm_en, tx_data_rdy, tx_data} !== {2'b01, 8'h61}) begin
            n_fail++; $display("FAIL alarm_off: got en=%b tx=%b/%h required 0 1/61", alarm_en, tx_data_rdy, tx_data);
        end
        drive(0, 1, "z");
        n_tests++;
        if (dut_vec !== exp_vec() || tx_data_rdy !== 1'b0) begin
            n_fail++; $display("FAIL alarm_ignore: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq[$] = '{"L", "1", "2", "3", "4", CR};
        drive(0, 1, "L"); drive(0, 1, "1"); drive(0, 1, "2");
        drive(1, 1, "3");
        n_tests++;
        if ({busy, ld_time, ld_alarm, tx_data_rdy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid: got busy=%b t=%b a=%b tx=%b required 0000", busy, ld_time, ld_alarm, tx_data_rdy);
        end
        foreach (seq[i]) begin
            drive(0, 1, seq[i]);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid byte %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if ({ld_alarm, ld_time, ld_value} !== {2'b10, 16'h1234}) begin
            n_fail++; $display("FAIL reset_mid_load: got a=%b t=%b v=%h required 1 0 1234", ld_alarm, ld_time, ld_value);
        end
    endtask

    task automatic test_random();
        logic [7:0] alpha[$] = '{"l", "L", "a", "0", "3", "5", "6", "9", CR, "x", "z", "A"};
        logic [7:0] cmd[$];
        int gap;
        for (int it = 0; it < 200; it++) begin
            cmd.delete();
            if ($urandom_range(0, 3) == 0) begin
                cmd.push_back(alpha[$urandom_range(0, alpha.size() - 1)]);
            end else begin
                cmd.push_back($urandom_range(0, 1) ? "l" : "L");
                cmd.push_back(8'(8'h30 + $urandom_range(0, 5)));
                cmd.push_back(8'(8'h30 + $urandom_range(0, 9)));
                cmd.push_back(8'(8'h30 + $urandom_range(0, 5)));
                cmd.push_back(8'(8'h30 + $urandom_range(0, 9)));
                cmd.push_back(CR);
                if ($urandom_range(0, 7) == 0) cmd[$urandom_range(1, 5)] = alpha[$urandom_range(0, alpha.size() - 1)];
            end
            foreach (cmd[i]) begin
                drive(0, 1, cmd[i]);
                n_tests++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random it %0d byte %h: got %h expected %h", it, cmd[i], dut_vec, exp_vec());
                end
                gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    drive($urandom_range(0, 199) == 0, 0, 0);
                    n_tests++;
                    if (dut_vec !== exp_vec()) begin
                        n_fail++; $display("FAIL random it %0d gap %0d: got %h expected %h", it, g, dut_vec, exp_vec());
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_time();
        test_load_alarm();
        test_errors();
        test_timeout();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
